// File: rtl/shift_sequencer.sv
// shift_sequencer: turns one multi-position shift request into a parallel
// load followed by AMOUNT single-step shift commands for a 4-bit shifter,
// then returns the shifted value and a sticky "any bit lost" flag.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] OPERAND,
  input  logic             DIR,
  input  logic [CNT_W-1:0] AMOUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             SHOUT,
  output logic [WIDTH-1:0] SH_DATA,
  output logic             SH_LOAD,
  output logic [1:0]       SH_CTRL,
  input  logic [WIDTH-1:0] SH_OUT,
  input  logic             SH_FLAG
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Shifter control encodings {LSH,RSH}
  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_LEFT  = 2'b10;
  localparam logic [1:0] CTRL_RIGHT = 2'b01;

  state_t             state_reg;
  state_t             state_next;

  logic [WIDTH-1:0]   op_reg;
  logic               dir_reg;
  logic [CNT_W-1:0]   amt_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               sticky_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               shout_reg;

  logic               busy_next;
  logic               done_next;
  logic               load_next;
  logic [1:0]         ctrl_next;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and Moore output decode; defaults first so nothing latches
  always_comb begin
    state_next = state_reg;
    busy_next  = 1'b1;
    done_next  = 1'b0;
    load_next  = 1'b0;
    ctrl_next  = CTRL_HOLD;
    case (state_reg)
      ST_IDLE: begin
        busy_next = 1'b0;
        if (START) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_next = 1'b1;
        if (amt_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Final SHIFT cycle (counter exhausted) only samples the last flag
        if (cnt_reg != '0) begin
          ctrl_next = dir_reg ? CTRL_RIGHT : CTRL_LEFT;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request capture, step counter, sticky flag and result registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      op_reg     <= '0;
      dir_reg    <= 1'b0;
      amt_reg    <= '0;
      cnt_reg    <= '0;
      sticky_reg <= 1'b0;
      result_reg <= '0;
      shout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            op_reg     <= OPERAND;
            dir_reg    <= DIR;
            amt_reg    <= AMOUNT;
            sticky_reg <= 1'b0;
          end
        end
        ST_LOAD: begin
          cnt_reg <= amt_reg;
        end
        ST_SHIFT: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
          // The first SHIFT cycle follows the load edge, so SH_FLAG is not
          // yet meaningful; every later SHIFT cycle follows a shift edge.
          if (cnt_reg != amt_reg) begin
            sticky_reg <= sticky_reg | SH_FLAG;
          end
        end
        ST_DONE: begin
          result_reg <= SH_OUT;
          shout_reg  <= sticky_reg;
        end
        default: begin
          cnt_reg <= '0;
        end
      endcase
    end
  end

  assign BUSY    = busy_next;
  assign DONE    = done_next;
  assign SH_LOAD = load_next;
  assign SH_CTRL = ctrl_next;
  assign SH_DATA = op_reg;
  assign RESULT  = result_reg;
  assign SHOUT   = shout_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: behavioural shifter, timeline-based
// reference model, per-cycle output comparison and directed requests.
module tb_shift_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [3:0] OPERAND = 4'd0;
  logic       DIR = 1'b0;
  logic [2:0] AMOUNT = 3'd0;
  logic       BUSY, DONE, SHOUT, SH_LOAD;
  logic [3:0] RESULT, SH_DATA;
  logic [1:0] SH_CTRL;
  logic [3:0] sh_reg;
  logic       sh_flag;

  int n_cmp = 0;
  int n_bad = 0;

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OPERAND(OPERAND), .DIR(DIR),
    .AMOUNT(AMOUNT), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .SHOUT(SHOUT),
    .SH_DATA(SH_DATA), .SH_LOAD(SH_LOAD), .SH_CTRL(SH_CTRL),
    .SH_OUT(sh_reg), .SH_FLAG(sh_flag)
  );

  always #5 CLK = ~CLK;

  // Behavioural 4-bit shifter the sequencer drives
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sh_reg  <= 4'd0;
      sh_flag <= 1'b0;
    end else if (SH_LOAD) begin
      sh_reg <= SH_DATA;
    end else if (SH_CTRL == 2'b10) begin
      sh_flag <= sh_reg[3];
      sh_reg  <= {sh_reg[2:0], 1'b0};
    end else if (SH_CTRL == 2'b01) begin
      sh_flag <= sh_reg[0];
      sh_reg  <= {1'b0, sh_reg[3:1]};
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] f_res(input logic [3:0] op, input logic d, input logic [2:0] a);
    logic [11:0] l;
    logic [11:0] r;
    l = {8'd0, op} << a;
    r = {op, 8'd0} >> a;
    return d ? r[11:8] : l[3:0];
  endfunction

  function automatic logic f_shout(input logic [3:0] op, input logic d, input logic [2:0] a);
    logic [11:0] l;
    logic [11:0] r;
    l = {8'd0, op} << a;
    r = {op, 8'd0} >> a;
    return d ? (|r[7:0]) : (|l[11:4]);
  endfunction

  function automatic int f_lat(input logic [2:0] a);
    return (a == 3'd0) ? 2 : int'(a) + 3;
  endfunction

  int         cyc;
  int         m_s;
  logic       m_active;
  logic [3:0] m_op;
  logic       m_dir;
  logic [2:0] m_amt;
  logic [3:0] m_res;
  logic       m_sh;

  // Cycle numbering: the START edge opens cycle m_s (the load cycle);
  // the request completes at the edge that opens cycle m_s + latency.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cyc      <= 0;
      m_s      <= 0;
      m_active <= 1'b0;
      m_op     <= 4'd0;
      m_dir    <= 1'b0;
      m_amt    <= 3'd0;
      m_res    <= 4'd0;
      m_sh     <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_active) begin
        if (cyc + 1 == m_s + f_lat(m_amt)) begin
          m_active <= 1'b0;
          m_res    <= f_res(m_op, m_dir, m_amt);
          m_sh     <= f_shout(m_op, m_dir, m_amt);
        end
      end else if (START) begin
        m_active <= 1'b1;
        m_s      <= cyc + 1;
        m_op     <= OPERAND;
        m_dir    <= DIR;
        m_amt    <= AMOUNT;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model timeline
  initial begin
    int rel;
    int e_ctrl;
    forever begin
      @(negedge CLK);
      rel    = cyc - m_s;
      e_ctrl = 0;
      if (m_active && m_amt != 3'd0 && rel >= 1 && rel <= int'(m_amt))
        e_ctrl = m_dir ? 1 : 2;
      chk("busy", int'(BUSY), int'(m_active));
      chk("done", int'(DONE), int'(m_active && rel == f_lat(m_amt) - 1));
      chk("sh_load", int'(SH_LOAD), int'(m_active && rel == 0));
      chk("sh_ctrl", int'(SH_CTRL), e_ctrl);
      chk("result", int'(RESULT), int'(m_res));
      chk("shout", int'(SHOUT), int'(m_sh));
      if (m_active && rel == 0) chk("sh_data", int'(SH_DATA), int'(m_op));
    end
  end

  // One request with hand-computed result, sticky flag and latency
  task automatic run_op(input logic [3:0] op, input logic d, input logic [2:0] a,
                        input logic [3:0] e_res, input logic e_sh, input int e_lat);
    int n;
    n = 0;
    @(negedge CLK);
    OPERAND = op; DIR = d; AMOUNT = a; START = 1'b1;
    @(posedge CLK);
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(negedge CLK);
      if (i == 1) START = 1'b0;
      if (DONE) n = i;
    end
    chk("latency", n, e_lat);
    @(negedge CLK);
    chk("lit_result", int'(RESULT), int'(e_res));
    chk("lit_shout", int'(SHOUT), int'(e_sh));
    $display("op=%b dir=%0d amt=%0d -> result=%b shout=%0d latency=%0d",
             op, d, a, RESULT, SHOUT, n);
  endtask

  initial begin
    int dn;
    int t1;
    int t2;
    int t3;
    int k;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_result", int'(RESULT), 0);

    run_op(4'b0110, 1'b0, 3'd1, 4'b1100, 1'b0, 4);
    run_op(4'b0111, 1'b1, 3'd2, 4'b0001, 1'b1, 5);

    // Reset in the middle of SHIFT abandons the request
    @(negedge CLK);
    OPERAND = 4'b1011; DIR = 1'b0; AMOUNT = 3'd3; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK) START = 1'b0;
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_ctrl", int'(SH_CTRL), 0);
    chk("rst_result", int'(RESULT), 0);
    chk("rst_shout", int'(SHOUT), 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge CLK);
      if (DONE) dn++;
    end
    chk("rst_no_done", dn, 0);
    $display("reset mid-shift: done pulses after reset=%0d", dn);

    run_op(4'b1001, 1'b0, 3'd0, 4'b1001, 1'b0, 2);
    run_op(4'b1000, 1'b0, 3'd7, 4'b0000, 1'b1, 10);

    // Back-to-back with START held high and operands churning while busy
    @(negedge CLK);
    OPERAND = 4'b0011; DIR = 1'b1; AMOUNT = 3'd1; START = 1'b1;
    t1 = 0; t2 = 0; t3 = 0; k = 0;
    for (int i = 1; i <= 40 && t3 == 0; i++) begin
      @(negedge CLK);
      OPERAND = 4'($urandom_range(0, 15));
      if (DONE) begin
        k++;
        if (k == 1) t1 = i;
        else if (k == 2) t2 = i;
        else t3 = i;
      end
    end
    START = 1'b0;
    chk("b2b_pulses", k, 3);
    chk("b2b_gap1", t2 - t1, 5);
    chk("b2b_gap2", t3 - t2, 5);
    $display("back-to-back: done at %0d %0d %0d", t1, t2, t3);
    repeat (6) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Controller that turns one multi-position shift request into a sequence of load and single-step shift commands for the 4-bit shift-register datapath.
- Accepts operand, direction and amount over a START/BUSY/DONE handshake. Loads the shifter, issues exactly AMOUNT single-bit shifts, then returns the result and a sticky shifted-out flag.
- Sits between the ALU decode/control path and the shifter. It is the only driver of the shifter's load and shift controls.

Parameters:
- WIDTH, 4: operand and shifter data width.
- CNT_W, 3: width of AMOUNT and the internal step counter.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request strobe; sampled only in IDLE.
- OPERAND  in  WIDTH  value to shift; captured with START.
- DIR  in  1  0 = left, 1 = right; captured with START.
- AMOUNT  in  CNT_W  number of positions; captured with START.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  WIDTH  shifted value; valid from DONE and held until the next DONE.
- SHOUT  out  1  sticky OR of every bit shifted out during the operation; updates with RESULT.
- SH_DATA  out  WIDTH  shifter parallel-load data.
- SH_LOAD  out  1  shifter load enable.
- SH_CTRL  out  2  shifter control {LSH,RSH}: 10 = left, 01 = right, 00 = hold; 11 is never driven.
- SH_OUT  in  WIDTH  shifter register contents.
- SH_FLAG  in  1  bit shifted out by the most recent shift edge.

Behaviour:
- Shifter contract:
  - A rising CLK with SH_LOAD=1 loads SH_DATA.
  - Otherwise SH_CTRL=10 or 01 shifts one position, zero-filling.
  - SH_OUT and SH_FLAG reflect that edge in the following cycle.
- States: IDLE, LOAD, SHIFT, DONE. All outputs are Moore.
- RESET (any time, including mid-operation):
  - state = IDLE.
  - BUSY = DONE = SH_LOAD = 0, SH_CTRL = 00, SH_DATA = 0.
  - RESULT = 0, SHOUT = 0, counter = 0, sticky = 0.
  - Operation in flight is abandoned with no DONE.
- IDLE: when START=1 at an edge, latch OPERAND, DIR and AMOUNT, clear sticky, go to LOAD. START while BUSY is ignored.
- LOAD (1 cycle): SH_LOAD=1, SH_DATA = latched operand, SH_CTRL=00.
  - Latched AMOUNT = 0 -> DONE.
  - Otherwise counter = AMOUNT, go to SHIFT.
- SHIFT:
  - SH_LOAD=0. SH_CTRL = 10 (DIR=0) or 01 (DIR=1) while counter > 0.
  - Counter decrements each edge.
  - Sticky |= SH_FLAG in every cycle that follows a shift edge.
  - When counter reaches 0, go to DONE. SH_CTRL is 00 in that last SHIFT cycle, which exists only to sample the final SH_FLAG.
  - SHIFT therefore lasts AMOUNT+1 cycles.
- DONE (1 cycle): DONE=1, RESULT <= SH_OUT, SHOUT <= sticky, SH_CTRL=00, then go to IDLE.
  - RESULT/SHOUT visible from the cycle after DONE.
  - START can be accepted in the IDLE cycle after DONE, so back-to-back requests have a 1-cycle gap.
- Latency from START edge to DONE high: AMOUNT=0 -> 2 cycles; AMOUNT=k>0 -> k+3 cycles.
- AMOUNT >= WIDTH runs the full count. Result is 0, and SHOUT = OR of all operand bits shifted out.
- SH_CTRL is never 11. SH_LOAD and a nonzero SH_CTRL are never asserted together.

Test Plan:
- Reset mid-SHIFT: START, OPERAND=1011, DIR=0, AMOUNT=3; assert RESET in SHIFT -> BUSY=0, DONE never pulses, RESULT=0, SHOUT=0, SH_CTRL=00 immediately (async).
- Left shift: OPERAND=0110, DIR=0, AMOUNT=1 -> DONE 4 cycles after START; RESULT=1100, SHOUT=0; exactly one cycle with SH_CTRL=10.
- Right shift with loss: OPERAND=0111, DIR=1, AMOUNT=2 -> RESULT=0001, SHOUT=1, DONE at START+5.
- Zero amount: OPERAND=1001, AMOUNT=0 -> no SH_CTRL activity, RESULT=1001, SHOUT=0, DONE at START+2.
- Over-shift: OPERAND=1000, DIR=0, AMOUNT=7 -> RESULT=0000, SHOUT=1, seven shift cycles, DONE at START+10.
- Back-to-back with ignored START: hold START high throughout; RESULT/SHOUT change only at DONE pulses; no request accepted while BUSY=1; second request starts in the IDLE cycle after DONE.
